// File: rtl/dlsc_pcie_s6_pkg.sv
// Shared definitions for the Spartan-6 PCIe command path: arbiter state encoding and
// port-index width helper.
package dlsc_pcie_s6_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StHold = 1'b1
  } cmdarb_state_e;

  // Width of externally visible port index fields (supports up to 8 ports).
  localparam int unsigned PortIdxBits = 3;

  // Internal index width for n ports; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dlsc_rr_arbiter.sv
// Round-robin selector: first asserted request at or above ptr, wrapping modulo PORTS.
module dlsc_rr_arbiter #(
  parameter int unsigned PORTS = 4,
  parameter int unsigned IDXW  = 2
) (
  input  logic [PORTS-1:0] req,
  input  logic [IDXW-1:0]  ptr,
  output logic [PORTS-1:0] grant,
  output logic [IDXW-1:0]  idx,
  output logic             any
);

  always_comb begin
    int unsigned cand;
    logic [IDXW-1:0] c;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    c     = '0;
    for (int unsigned i = 0; i < PORTS; i++) begin
      cand = 32'(ptr) + i;
      if (cand >= PORTS) cand = cand - PORTS;
      c = IDXW'(cand);
      if (!any && req[c]) begin
        any      = 1'b1;
        grant[c] = 1'b1;
        idx      = c;
      end
    end
  end

endmodule

// File: rtl/dlsc_pcie_s6_cmdarb.sv
// Round-robin command arbiter feeding the PCIe request splitter, with per-port outstanding
// limits. Define DLSC_PCIE_S6_CMDARB_ERRCHK_EN to enable the err pulse on bogus completions.
module dlsc_pcie_s6_cmdarb #(
  parameter int unsigned PORTS   = 4,
  parameter int unsigned ADDR    = 32,
  parameter int unsigned META    = 1,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  output logic [PORTS-1:0]          in_ready,
  input  logic [PORTS-1:0]          in_valid,
  input  logic [PORTS*(ADDR-2)-1:0] in_addr,
  input  logic [PORTS*10-1:0]       in_len,
  input  logic [PORTS*META-1:0]     in_meta,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [ADDR-3:0]           out_addr,
  output logic [9:0]                out_len,
  output logic [META-1:0]           out_meta,
  output logic [2:0]                out_port,
  input  logic                      done_valid,
  input  logic [2:0]                done_port,
  output logic [PORTS-1:0]          busy,
  output logic                      err
);
  import dlsc_pcie_s6_pkg::*;

  localparam int unsigned AW   = ADDR - 2;
  localparam int unsigned IDXW = idx_width(PORTS);
  localparam int unsigned CW   = $clog2(MAX_OUT + 1);

  cmdarb_state_e    state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [IDXW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]    outstanding_q [PORTS];
  logic [CW-1:0]    outstanding_d [PORTS];
  logic [PORTS-1:0] busy_q, busy_d;

  logic [AW-1:0]    out_addr_q, out_addr_d;
  logic [9:0]       out_len_q, out_len_d;
  logic [META-1:0]  out_meta_q, out_meta_d;
  logic [2:0]       out_port_q, out_port_d;

  logic [PORTS-1:0] eligible;
  logic [PORTS-1:0] arb_grant;
  logic [IDXW-1:0]  arb_idx;
  logic             arb_any;
  logic             grant_fire;

  always_comb begin
    for (int unsigned p = 0; p < PORTS; p++) begin
      eligible[p] = in_valid[p] && (32'(outstanding_q[p]) < MAX_OUT);
    end
  end

  dlsc_rr_arbiter #(
    .PORTS (PORTS),
    .IDXW  (IDXW)
  ) u_arb (
    .req   (eligible),
    .ptr   (rr_ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  assign grant_fire = (state_q == StIdle) && enable && arb_any;
  assign in_ready   = grant_fire ? arb_grant : '0;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    out_addr_d  = out_addr_q;
    out_len_d   = out_len_q;
    out_meta_d  = out_meta_q;
    out_port_d  = out_port_q;
    unique case (state_q)
      StIdle: begin
        if (grant_fire) begin
          state_d     = StHold;
          out_valid_d = 1'b1;
          out_port_d  = 3'(arb_idx);
          for (int unsigned p = 0; p < PORTS; p++) begin
            if (arb_grant[p]) begin
              out_addr_d = in_addr[p*AW +: AW];
              out_len_d  = in_len[p*10 +: 10];
              out_meta_d = in_meta[p*META +: META];
            end
          end
        end
      end
      StHold: begin
        // Exit cycle never grants, so the pointer update cannot race a new selection.
        if (out_ready) begin
          state_d     = StIdle;
          out_valid_d = 1'b0;
          rr_ptr_d    = (32'(out_port_q) + 1 >= PORTS) ? '0 : IDXW'(out_port_q + 3'd1);
        end
      end
    endcase
  end

  always_comb begin
    logic inc, dec;
    inc = 1'b0;
    dec = 1'b0;
    for (int unsigned p = 0; p < PORTS; p++) begin
      inc = grant_fire && arb_grant[p];
      // Completions for idle or nonexistent ports are dropped rather than wrapping.
      dec = done_valid && (done_port == 3'(p)) && (outstanding_q[p] != '0);
      outstanding_d[p] = outstanding_q[p];
      if (inc && !dec) begin
        outstanding_d[p] = outstanding_q[p] + CW'(1);
      end else if (dec && !inc) begin
        outstanding_d[p] = outstanding_q[p] - CW'(1);
      end
      busy_d[p] = (outstanding_d[p] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
      busy_q      <= '0;
      for (int unsigned p = 0; p < PORTS; p++) outstanding_q[p] <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
      busy_q      <= busy_d;
      for (int unsigned p = 0; p < PORTS; p++) outstanding_q[p] <= outstanding_d[p];
    end
  end

  // Payload registers carry no reset; out_valid qualifies them.
  always_ff @(posedge clk) begin
    out_addr_q <= out_addr_d;
    out_len_q  <= out_len_d;
    out_meta_q <= out_meta_d;
    out_port_q <= out_port_d;
  end

`ifdef DLSC_PCIE_S6_CMDARB_ERRCHK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = done_valid && (32'(done_port) >= PORTS);
    for (int unsigned p = 0; p < PORTS; p++) begin
      if (done_valid && (done_port == 3'(p)) && (outstanding_q[p] == '0)) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_len   = out_len_q;
  assign out_meta  = out_meta_q;
  assign out_port  = out_port_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_dlsc_pcie_s6_cmdarb.sv
// Directed bench for dlsc_pcie_s6_cmdarb (4 ports, MAX_OUT=2).
module tb_dlsc_pcie_s6_cmdarb;

  localparam int unsigned PORTS = 4;
  localparam int unsigned ADDR  = 32;
  localparam int unsigned META  = 1;
  localparam int unsigned AW    = ADDR - 2;
`ifdef DLSC_PCIE_S6_CMDARB_ERRCHK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic                  clk;
  logic                  rst;
  logic                  enable;
  logic [PORTS-1:0]      in_ready;
  logic [PORTS-1:0]      in_valid;
  logic [PORTS*AW-1:0]   in_addr;
  logic [PORTS*10-1:0]   in_len;
  logic [PORTS*META-1:0] in_meta;
  logic                  out_ready;
  logic                  out_valid;
  logic [AW-1:0]         out_addr;
  logic [9:0]            out_len;
  logic [META-1:0]       out_meta;
  logic [2:0]            out_port;
  logic                  done_valid;
  logic [2:0]            done_port;
  logic [PORTS-1:0]      busy;
  logic                  err;

  int n_tests = 0;
  int n_fail  = 0;

  dlsc_pcie_s6_cmdarb #(
    .PORTS   (PORTS),
    .ADDR    (ADDR),
    .META    (META),
    .MAX_OUT (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .in_ready   (in_ready),
    .in_valid   (in_valid),
    .in_addr    (in_addr),
    .in_len     (in_len),
    .in_meta    (in_meta),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_addr   (out_addr),
    .out_len    (out_len),
    .out_meta   (out_meta),
    .out_port   (out_port),
    .done_valid (done_valid),
    .done_port  (done_port),
    .busy       (busy),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [AW-1:0] addr_of(input int p);
    return AW'(32'h0012_3400 + p * 17);
  endfunction

  function automatic logic [9:0] len_of(input int p);
    return 10'(p * 3 + 1);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic retire(input int p);
    done_valid = 1'b1;
    done_port  = 3'(p);
    step();
    done_valid = 1'b0;
  endtask

  initial begin
    int order [5];
    order = '{0, 1, 2, 3, 0};
    rst        = 1'b1;
    enable     = 1'b1;
    in_valid   = '0;
    out_ready  = 1'b1;
    done_valid = 1'b0;
    done_port  = '0;
    in_meta    = 4'b0101;
    for (int p = 0; p < 4; p++) begin
      in_addr[p*AW +: AW] = addr_of(p);
      in_len[p*10 +: 10]  = len_of(p);
    end
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err), 0);

    // Ports 0 and 2 valid: grant 0, then 2 two cycles later.
    in_valid = 4'b0101;
    #1;
    chk("p02_rdy0", 32'(in_ready), 32'b0001);
    step();
    chk("p02_v0", 32'(out_valid), 1);
    chk("p02_port0", 32'(out_port), 0);
    chk("p02_addr0", 32'(out_addr), 32'(addr_of(0)));
    chk("p02_len0", 32'(out_len), 32'(len_of(0)));
    chk("p02_meta0", 32'(out_meta), 1);
    chk("p02_busy0", 32'(busy), 32'b0001);
    in_valid = 4'b0100;
    #1;
    chk("p02_hold_rdy", 32'(in_ready), 0);
    step();
    chk("p02_exit_v", 32'(out_valid), 0);
    chk("p02_rdy2", 32'(in_ready), 32'b0100);
    step();
    chk("p02_v2", 32'(out_valid), 1);
    chk("p02_port2", 32'(out_port), 2);
    chk("p02_addr2", 32'(out_addr), 32'(addr_of(2)));
    chk("p02_busy2", 32'(busy), 32'b0101);
    in_valid = '0;
    step();
    retire(0);
    retire(2);
    chk("p02_busy_end", 32'(busy), 0);

    // All ports valid after reset: 0,1,2,3,0.
    rst = 1'b1;
    step();
    rst = 1'b0;
    in_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rr_rdy", 32'(in_ready), 32'(1) << order[k]);
      step();
      chk("rr_v", 32'(out_valid), 1);
      chk("rr_port", 32'(out_port), 32'(order[k]));
      step();
    end
    in_valid = '0;
    retire(0);
    retire(0);
    retire(1);
    retire(2);
    retire(3);
    chk("rr_busy_end", 32'(busy), 0);

    // Outstanding limit of 2 on port 1.
    in_valid = 4'b0010;
    for (int g = 0; g < 2; g++) begin
      #1;
      chk("lim_rdy", 32'(in_ready), 32'b0010);
      step();
      chk("lim_port", 32'(out_port), 1);
      step();
    end
    chk("lim_full_rdy", 32'(in_ready), 0);
    step();
    step();
    chk("lim_full_rdy2", 32'(in_ready), 0);
    chk("lim_full_v", 32'(out_valid), 0);
    done_valid = 1'b1;
    done_port  = 3'd1;
    #1;
    chk("lim_done_rdy", 32'(in_ready), 0);
    step();
    done_valid = 1'b0;
    #1;
    chk("lim_third_rdy", 32'(in_ready), 32'b0010);
    step();
    chk("lim_third_v", 32'(out_valid), 1);
    chk("lim_third_port", 32'(out_port), 1);
    in_valid = '0;
    step();
    retire(1);
    retire(1);
    chk("lim_busy_end", 32'(busy), 0);

    // Backpressure: payload held while out_ready=0, enable drop does not abort.
    out_ready = 1'b0;
    in_valid  = 4'b0001;
    #1;
    chk("bp_rdy", 32'(in_ready), 32'b0001);
    step();
    in_valid = 4'b1111;
    enable   = 1'b0;
    in_addr[0 +: AW] = AW'(32'h0fed_cba0);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_v", 32'(out_valid), 1);
      chk("bp_port", 32'(out_port), 0);
      chk("bp_addr", 32'(out_addr), 32'(addr_of(0)));
      chk("bp_rdy_hold", 32'(in_ready), 0);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("bp_exit_v", 32'(out_valid), 0);
    chk("dis_rdy", 32'(in_ready), 0);
    step();
    chk("dis_v", 32'(out_valid), 0);
    enable   = 1'b1;
    in_valid = '0;
    in_addr[0 +: AW] = addr_of(0);
    retire(0);
    chk("bp_busy_end", 32'(busy), 0);

    // Simultaneous grant and done on port 3.
    in_valid = 4'b1000;
    #1;
    chk("sim_rdy", 32'(in_ready), 32'b1000);
    step();
    step();
    chk("sim_busy1", 32'(busy), 32'b1000);
    done_valid = 1'b1;
    done_port  = 3'd3;
    #1;
    chk("sim_rdy2", 32'(in_ready), 32'b1000);
    step();
    done_valid = 1'b0;
    in_valid   = '0;
    chk("sim_busy_keep", 32'(busy), 32'b1000);
    chk("sim_port", 32'(out_port), 3);
    step();
    retire(3);
    chk("sim_busy_end", 32'(busy), 0);

    // Bogus completions: out-of-range port, then port with nothing outstanding.
    retire(5);
    chk("bad5_err", 32'(err), 32'(ERR_EXP));
    chk("bad5_busy", 32'(busy), 0);
    step();
    chk("bad5_err_clr", 32'(err), 0);
    retire(0);
    chk("bad0_err", 32'(err), 32'(ERR_EXP));
    chk("bad0_busy", 32'(busy), 0);
    step();
    chk("bad0_err_clr", 32'(err), 0);
    in_valid = 4'b0001;
    #1;
    chk("bad0_no_wrap", 32'(in_ready), 32'b0001);

    // Reset while holding a command.
    out_ready = 1'b0;
    step();
    chk("rh_v", 32'(out_valid), 1);
    chk("rh_busy", 32'(busy), 32'b0001);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rh_v_rst", 32'(out_valid), 0);
    chk("rh_busy_rst", 32'(busy), 0);
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    #1;
    chk("rh_first_rdy", 32'(in_ready), 32'b0001);
    step();
    chk("rh_first_port", 32'(out_port), 0);
    chk("rh_first_v", 32'(out_valid), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
